program_loader: RTL

- Write-side counterpart to the multi-cycle machine's program readout (programOut).
- Accepts a byte stream from a host/bench over a valid/ready handshake and packs bytes into instructionWidth words.
- Writes the words sequentially into the machine's program memory.
- Holds the machine in reset (cpuHold) while loading; releases it after a fixed settle period once the load completes.

---
 rtl/program_loader_pkg.sv | 26 ++
 rtl/program_loader_if.sv | 42 ++++
 rtl/program_loader_byte_packer.sv | 57 +++++
 rtl/program_loader.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared widths, state encodings and hold period for the program loader
package program_loader_pkg;

  // Default program word width and program memory address width
  localparam int DEFAULT_INSTRUCTION_WIDTH = 16;
  localparam int DEFAULT_ADDRESS_WIDTH     = 8;

  // Cycles the machine stays held after the last write before release
  localparam int DEFAULT_HOLD_CYCLES       = 4;

  // FSM state encodings; kept as plain 3-bit constants so older tooling can match them
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_WRITE   = 3'd2;
  localparam state_t ST_VERIFY  = 3'd3;
  localparam state_t ST_RELEASE = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  // Bytes that make up one program word
  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream and program memory bus (memRdData present with PROGRAM_LOADER_VERIFY_EN)
interface program_loader_if #(
  parameter int instructionWidth = program_loader_pkg::DEFAULT_INSTRUCTION_WIDTH,
  parameter int addressWidth     = program_loader_pkg::DEFAULT_ADDRESS_WIDTH
);

  // Host byte stream
  logic [7:0]                  inData;
  logic                        inValid;
  logic                        inReady;

  // Program memory write port
  logic                        memWe;
  logic [addressWidth-1:0]     memAddr;
  logic [instructionWidth-1:0] memData;

`ifdef PROGRAM_LOADER_VERIFY_EN
  // Program memory read data, one cycle after memAddr
  logic [instructionWidth-1:0] memRdData;

  modport master (
    output inData, inValid, memRdData,
    input  inReady, memWe, memAddr, memData
  );

  modport slave (
    input  inData, inValid, memRdData,
    output inReady, memWe, memAddr, memData
  );
`else
  modport master (
    output inData, inValid,
    input  inReady, memWe, memAddr, memData
  );

  modport slave (
    input  inData, inValid,
    output inReady, memWe, memAddr, memData
  );
`endif

endinterface

// File: rtl/program_loader_byte_packer.sv
// rtl/program_loader_byte_packer.sv - packs MSB-first bytes into program words and flags the last byte of each word
module program_loader_byte_packer #(
  parameter int instructionWidth = program_loader_pkg::DEFAULT_INSTRUCTION_WIDTH
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        restart,
  input  logic                        byteValid,
  input  logic [7:0]                  byteData,
  output logic [instructionWidth-1:0] word,
  output logic                        wordDone
);

  import program_loader_pkg::*;

  localparam int BPW = bytes_per_word(instructionWidth);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0] byteCnt;

  // The accepted byte completes a word when it is the BPW-th of the group
  assign wordDone = byteValid && (byteCnt == CW'(BPW - 1));

  // Byte position within the current word; wraps on the last byte so the next word starts clean
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      byteCnt <= '0;
    end else if (restart) begin
      byteCnt <= '0;
    end else if (byteValid) begin
      byteCnt <= wordDone ? '0 : byteCnt + CW'(1);
    end
  end

  generate
    if (BPW == 1) begin : g_single
      // A one-byte word is just the byte
      always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
          word <= '0;
        end else if (byteValid) begin
          word <= byteData;
        end
      end
    end else begin : g_shift
      // Shift in from the LSB side so the first byte of a word ends up as its MSB
      always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
          word <= '0;
        end else if (byteValid) begin
          word <= {word[instructionWidth-9:0], byteData};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a byte stream into program memory while holding the machine; readback check with PROGRAM_LOADER_VERIFY_EN
module program_loader
  import program_loader_pkg::*;
#(
  parameter int instructionWidth = DEFAULT_INSTRUCTION_WIDTH,
  parameter int addressWidth     = DEFAULT_ADDRESS_WIDTH,
  parameter int HOLD_CYCLES      = DEFAULT_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic [addressWidth:0] wordCount,
  program_loader_if.slave       bus,
  output logic                  cpuHold,
  output logic                  busy,
  output logic                  done,
  output logic                  lenErr
`ifdef PROGRAM_LOADER_VERIFY_EN
  ,
  output logic                  verifyErr
`endif
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t                      state;
  logic [addressWidth:0]       wordIdx;
  logic [addressWidth:0]       wordIdxNext;
  logic [addressWidth:0]       wordTotal;
  logic [HCW-1:0]              holdCnt;
  logic                        startOk;
  logic                        tooLong;
  logic                        accept;
  logic                        wordReady;
  logic [instructionWidth-1:0] word;

  // A start only counts while the loader is idle or finished
  assign startOk     = start && ((state == ST_IDLE) || (state == ST_DONE));
  // More than 2^addressWidth words cannot fit: top bit set with any lower bit set
  assign tooLong     = wordCount[addressWidth] && (|wordCount[addressWidth-1:0]);
  assign accept      = bus.inValid && (state == ST_LOAD);
  assign wordIdxNext = wordIdx + (addressWidth + 1)'(1);

  program_loader_byte_packer #(
    .instructionWidth(instructionWidth)
  ) u_packer (
    .clk       (clk),
    .clear     (clear),
    .restart   (startOk),
    .byteValid (accept),
    .byteData  (bus.inData),
    .word      (word),
    .wordDone  (wordReady)
  );

`ifdef PROGRAM_LOADER_VERIFY_EN
  logic [instructionWidth-1:0] csumWr;
  logic [instructionWidth-1:0] csumRd;
  logic                        verifyLast;
  logic                        verifyOk;

  // Last verify cycle: the read for the final word lands now, one cycle after its address
  assign verifyLast = (state == ST_VERIFY) && (wordIdx == wordTotal);
  assign verifyOk   = ((csumRd ^ bus.memRdData) == csumWr);

  // Running XOR of written words and of read-back words
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      csumWr <= '0;
      csumRd <= '0;
    end else if (startOk) begin
      csumWr <= '0;
      csumRd <= '0;
    end else begin
      if (state == ST_WRITE) begin
        csumWr <= csumWr ^ word;
      end
      if ((state == ST_VERIFY) && (wordIdx != '0)) begin
        csumRd <= csumRd ^ bus.memRdData;
      end
    end
  end

  // Sticky readback mismatch flag, cleared by the next accepted start
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      verifyErr <= 1'b0;
    end else if (startOk) begin
      verifyErr <= 1'b0;
    end else if (verifyLast && !verifyOk) begin
      verifyErr <= 1'b1;
    end
  end
`endif

  // Load sequencing: word index, latched length, hold counter and length error
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= ST_IDLE;
      wordIdx   <= '0;
      wordTotal <= '0;
      holdCnt   <= '0;
      lenErr    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            wordTotal <= wordCount;
            wordIdx   <= '0;
            holdCnt   <= '0;
            if (tooLong) begin
              lenErr <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              lenErr <= 1'b0;
              state  <= (wordCount == '0) ? ST_RELEASE : ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (wordReady) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wordIdxNext == wordTotal) begin
`ifdef PROGRAM_LOADER_VERIFY_EN
            wordIdx <= '0;
            state   <= ST_VERIFY;
`else
            wordIdx <= wordIdxNext;
            state   <= ST_RELEASE;
`endif
          end else begin
            wordIdx <= wordIdxNext;
            state   <= ST_LOAD;
          end
        end
`ifdef PROGRAM_LOADER_VERIFY_EN
        ST_VERIFY: begin
          wordIdx <= wordIdxNext;
          if (verifyLast) begin
            state <= verifyOk ? ST_RELEASE : ST_IDLE;
          end
        end
`endif
        ST_RELEASE: begin
          if (holdCnt == HCW'(HOLD_CYCLES - 1)) begin
            state <= ST_DONE;
          end else begin
            holdCnt <= holdCnt + HCW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.inReady = (state == ST_LOAD);
  assign bus.memWe   = (state == ST_WRITE);
  assign bus.memAddr = wordIdx[addressWidth-1:0];
  assign bus.memData = word;

  // The machine runs only once a load has fully completed
  assign cpuHold = (state != ST_DONE);
  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);

endmodule
